// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand and result handshakes of the nibble-serial add controller.
// The controller takes the slave side; the producer/consumer takes the master side.
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output in_valid, op_a, op_b, op_ci, out_ready,
    input  in_ready, out_valid, sum, carry_out
  );

  modport slave (
    input  in_valid, op_a, op_b, op_ci, out_ready,
    output in_ready, out_valid, sum, carry_out
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder built by reusing one external 4-bit slice, one nibble per clock, LSB first.
// Optional macro SERIAL_ADD_OVF_EN adds a two's-complement overflow output (ovf).
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  nibble_serial_add_ctrl_if.slave io,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_ci,
  input  logic [3:0] add_sum,
  input  logic       add_co,
`ifdef SERIAL_ADD_OVF_EN
  output logic       ovf,
`endif
  output logic       busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             carry_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic [WIDTH-1:0] word_s;
  logic             accept_s;
  logic             last_s;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_r;
`endif

  assign io.in_ready  = (state_r == IDLE) && !reset;
  assign io.out_valid = (state_r == DONE);
  assign io.sum       = sum_r;
  assign io.carry_out = cout_r;
  assign busy         = (state_r != IDLE);
`ifdef SERIAL_ADD_OVF_EN
  assign ovf          = ovf_r;
`endif

  assign accept_s = io.in_valid && io.in_ready;
  assign last_s   = (state_r == RUN) && (count_r == CW'(NIBBLES - 1));

  // Partial sum: earlier nibbles collect at the top and slide down, so the
  // final slice result lands in the MSB nibble of the assembled word.
  generate
    if (NIBBLES == 1) begin : g_single
      assign word_s = add_sum;
    end else begin : g_multi
      logic [WIDTH-5:0] part_r;

      // Partial-sum shift register.
      always_ff @(posedge clk) begin
        if (reset) begin
          part_r <= '0;
        end else if (state_r == RUN) begin
          part_r <= word_s[WIDTH-1:4];
        end else begin
          part_r <= part_r;
        end
      end

      assign word_s = {add_sum, part_r};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = RUN;
        else          state_next_s = IDLE;
      end
      RUN: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = RUN;
      end
      DONE: begin
        if (io.out_ready) state_next_s = IDLE;
        else              state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Slice drive comes from registers only, so operands never reach the slice combinationally.
  always_comb begin
    add_a  = 4'd0;
    add_b  = 4'd0;
    add_ci = 1'b0;
    if (state_r == RUN) begin
      add_a  = a_sh_r[3:0];
      add_b  = b_sh_r[3:0];
      add_ci = carry_r;
    end else begin
      add_a  = 4'd0;
      add_b  = 4'd0;
      add_ci = 1'b0;
    end
  end

  // Operand shifters, carry recirculation, nibble counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      carry_r <= 1'b0;
      count_r <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else if (accept_s) begin
      a_sh_r  <= io.op_a;
      b_sh_r  <= io.op_b;
      carry_r <= io.op_ci;
      count_r <= '0;
    end else if (state_r == RUN) begin
      a_sh_r  <= a_sh_r >> 4'd4;
      b_sh_r  <= b_sh_r >> 4'd4;
      carry_r <= add_co;
      count_r <= count_r + CW'(1);
      if (last_s) begin
        sum_r  <= word_s;
        cout_r <= add_co;
`ifdef SERIAL_ADD_OVF_EN
        // Signs of the MSB nibble inputs agree but the result sign differs.
        ovf_r  <= (a_sh_r[3] == b_sh_r[3]) && (add_sum[3] != a_sh_r[3]);
`endif
      end else begin
        sum_r  <= sum_r;
        cout_r <= cout_r;
      end
    end else begin
      a_sh_r  <= a_sh_r;
      b_sh_r  <= b_sh_r;
      carry_r <= carry_r;
      count_r <= count_r;
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl: models the 4-bit slice, keeps an
// arithmetic reference of each accepted operation and checks outputs every cycle.
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] add_a, add_b, add_sum;
  logic       add_ci, add_co, busy;
  logic       ovf_w;
  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 1'b0;

  nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) io ();

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .io      (io),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_ci  (add_ci),
    .add_sum (add_sum),
    .add_co  (add_co),
`ifdef SERIAL_ADD_OVF_EN
    .ovf     (ovf_w),
`endif
    .busy    (busy)
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf_w = 1'b0;
`endif

  // The shared 4-bit ripple slice.
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_ci};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one pending operation, result due NIBBLES edges after acceptance.
  bit               m_active = 1'b0, m_valid = 1'b0;
  int               m_left = 0;
  int               cyc = 0;
  logic [WIDTH-1:0] m_a, m_b;
  logic             m_ci;
  logic [WIDTH:0]   m_res;
  int               acc_q[$];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_active = 1'b0;
      m_valid  = 1'b0;
      m_left   = 0;
    end else if (!m_active && io.in_valid) begin
      m_active = 1'b1;
      m_left   = NIBBLES;
      m_a      = io.op_a;
      m_b      = io.op_b;
      m_ci     = io.op_ci;
      m_res    = {1'b0, io.op_a} + {1'b0, io.op_b} + {{WIDTH{1'b0}}, io.op_ci};
      acc_q.push_back(cyc);
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_valid = 1'b1;
    end else if (m_valid && io.out_ready) begin
      m_valid  = 1'b0;
      m_active = 1'b0;
    end
  end

  // Per-cycle comparison against the reference.
  always @(negedge clk) begin
    logic [WIDTH:0] msk, low;
    int k;
    if (chk_en) begin
      chk("in_ready", io.in_ready, !m_active && !reset);
      chk("busy", busy, m_active);
      chk("out_valid", io.out_valid, m_valid);
      if (m_valid) begin
        chk("sum", io.sum, m_res[WIDTH-1:0]);
        chk("carry_out", io.carry_out, m_res[WIDTH]);
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", ovf_w, (m_a[WIDTH-1] == m_b[WIDTH-1]) && (m_res[WIDTH-1] != m_a[WIDTH-1]));
`endif
      end
      if (m_active && m_left > 0) begin
        k   = NIBBLES - m_left;
        msk = ~({(WIDTH+1){1'b1}} << (4 * k));
        low = ({1'b0, m_a} & msk) + ({1'b0, m_b} & msk) + {{WIDTH{1'b0}}, m_ci};
        chk("add_a", add_a, (m_a >> (4 * k)) & 'hF);
        chk("add_b", add_b, (m_b >> (4 * k)) & 'hF);
        chk("add_ci", add_ci, low[4*k]);
      end else begin
        chk("add_idle", {add_a, add_b, add_ci}, 9'd0);
      end
    end
  end

  // One operation with out_ready low, then hold for 'hold' cycles before releasing.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                       input logic [WIDTH-1:0] exp_sum, input logic exp_co, input int hold,
                       output logic [NIBBLES-1:0] ci_seq, output logic ovf_got);
    int n;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    io.in_valid  = 1'b1;
    io.op_a = a; io.op_b = b; io.op_ci = ci;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    io.op_a = ~a; io.op_b = ~b; io.op_ci = ~ci;
    ci_seq    = '0;
    ci_seq[0] = add_ci;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (io.out_valid) break;
      if (n < NIBBLES) ci_seq[n] = add_ci;
    end
    chk("latency", n, NIBBLES);
    chk("op_sum", io.sum, exp_sum);
    chk("op_carry", io.carry_out, exp_co);
    ovf_got = ovf_w;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_sum", io.sum, exp_sum);
      chk("hold_valid", io.out_valid, 1'b1);
      chk("hold_in_ready", io.in_ready, 1'b0);
    end
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", io.out_valid, 1'b0);
    chk("release_in_ready", io.in_ready, 1'b1);
    io.out_ready = 1'b0;
  endtask

  logic [NIBBLES-1:0] cis;
  logic               ov;
  logic [WIDTH-1:0]   tbl_a[4] = '{16'h1111, 16'hFFFF, 16'h8000, 16'h0F0F};
  logic [WIDTH-1:0]   tbl_b[4] = '{16'h2222, 16'hFFFF, 16'h8000, 16'hF0F0};
  logic               tbl_c[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    io.in_valid = 1'b0; io.out_ready = 1'b0;
    io.op_a = '0; io.op_b = '0; io.op_ci = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", io.in_ready, 1'b0);
    chk("rst_state", {io.out_valid, busy, io.carry_out}, 3'd0);
    chk("rst_sum", io.sum, 16'h0000);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", io.in_ready, 1'b1);

    // Simple add, no carry out.
    do_op(16'h00FA, 16'h0002, 1'b0, 16'h00FC, 1'b0, 0, cis, ov);
    chk("t1_ci_seq", cis, 4'b0000);
    // Carry ripples through every nibble.
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, cis, ov);
    chk("t2_ci_seq", cis, 4'b1110);
    // Carry in plus back-pressure.
    do_op(16'h000A, 16'h0002, 1'b1, 16'h000D, 1'b0, 5, cis, ov);
    chk("t3_ci_seq", cis, 4'b0001);

    // Reset mid-RUN aborts.
    @(posedge clk); #1;
    io.out_ready = 1'b1; io.in_valid = 1'b1;
    io.op_a = 16'h5555; io.op_b = 16'h1111; io.op_ci = 1'b0;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_in_ready", io.in_ready, 1'b1);
    chk("abort_valid", io.out_valid, 1'b0);
    for (int i = 0; i < 8; i++) @(posedge clk);
    #1;
    do_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 0, cis, ov);

    // Back-to-back operations with in_valid held high.
    acc_q.delete();
    @(posedge clk); #1;
    io.out_ready = 1'b1; io.in_valid = 1'b1;
    io.op_a = tbl_a[0]; io.op_b = tbl_b[0]; io.op_ci = tbl_c[0];
    begin
      int idx = 0;
      for (int c = 0; c < 60 && acc_q.size() < 4; c++) begin
        @(posedge clk); #1;
        if (m_active && m_left == NIBBLES) begin
          idx++;
          if (idx < 4) begin
            io.op_a = tbl_a[idx]; io.op_b = tbl_b[idx]; io.op_ci = tbl_c[idx];
          end else begin
            io.in_valid = 1'b0;
          end
        end
      end
    end
    for (int i = 0; i < 8; i++) @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    chk("b2b_accepts", acc_q.size(), 4);
    if (acc_q.size() == 4) begin
      chk("b2b_gap", acc_q[1] - acc_q[0], NIBBLES + 2);
      chk("b2b_span", acc_q[3] - acc_q[0], 3 * (NIBBLES + 2));
    end

`ifdef SERIAL_ADD_OVF_EN
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 0, cis, ov);
    chk("ovf_pos", ov, 1'b1);
    do_op(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 0, cis, ov);
    chk("ovf_neg", ov, 1'b1);
    do_op(16'h1000, 16'h2000, 1'b0, 16'h3000, 1'b0, 0, cis, ov);
    chk("ovf_none", ov, 1'b0);
`endif

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit additions by time-multiplexing one external 4-bit ripple adder slice (addbit-chain adder), one nibble per clock, LSB nibble first. Operands enter through a valid/ready handshake. The controller shifts nibbles into the slice, recirculates the slice carry, assembles the wide sum, and presents it through a valid/ready output handshake. It sits between an operand producer and the shared 4-bit adder, so the adder is reused for arbitrary word widths.

Parameters:
WIDTH, 16, operand/result width in bits; multiple of 4, minimum 4.
NIBBLES, WIDTH/4, derived slice count; localparam, not overridable.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand request
in_ready  output  1  controller can accept operands
op_a  input  WIDTH  first operand
op_b  input  WIDTH  second operand
op_ci  input  1  carry into nibble 0
add_a  output  4  nibble to adder slice input r1
add_b  output  4  nibble to adder slice input r2
add_ci  output  1  carry to adder slice
add_sum  input  4  adder slice result
add_co  input  1  adder slice carry out
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  assembled result
carry_out  output  1  carry out of MSB nibble
busy  output  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE (registered). in_ready = (state==IDLE) && !reset. busy = (state!=IDLE).
- Reset (sampled at clk edge): state=IDLE, nibble counter=0, carry reg=0, sum=0, carry_out=0, out_valid=0. Reset in RUN or DONE aborts the operation; no out_valid pulse follows.
- IDLE: in_valid && in_ready at an edge latches op_a/op_b into shift regs, carry reg<=op_ci, count<=0, state->RUN. in_valid without acceptance has no effect.
- RUN: add_a=a_sh[3:0], add_b=b_sh[3:0], add_ci=carry reg (combinational from registers only; no input-to-output path). Each edge: sum shift reg <= {add_sum, sum_sh[WIDTH-1:4]}, carry reg<=add_co, a_sh/b_sh shift right 4, count++. At the edge where count==NIBBLES-1: carry_out<=add_co, sum<=final assembled word, state->DONE.
- Outside RUN: add_a=0, add_b=0, add_ci=0.
- DONE: out_valid=1. sum/carry_out held stable while out_valid && !out_ready. out_ready at an edge -> IDLE, out_valid=0 next cycle. in_ready stays 0 in DONE, so no same-cycle accept.
- Latency: out_valid rises exactly NIBBLES cycles after the accept edge. Best throughput is one op per NIBBLES+2 cycles.
- op_a/op_b/op_ci changes after the accept edge are ignored.
- Arithmetic: unsigned modulo 2^WIDTH. carry_out is bit WIDTH of op_a+op_b+op_ci.
- WIDTH=4: a single RUN cycle.

Optional Feature:
Macro SERIAL_ADD_OVF_EN. When defined, adds output port ovf (1 bit), the two's-complement overflow flag. ovf is registered at the final RUN edge as (a_sh[3]==b_sh[3]) && (add_sum[3]!=a_sh[3]), reset to 0, and held with sum. When undefined, the port and its logic are absent.

Test Plan:
1. WIDTH=16, accept 0x00FA + 0x0002, ci=0 -> out_valid exactly 4 cycles later, sum=0x00FC, carry_out=0.
2. 0xFFFF + 0x0001, ci=0 -> sum=0x0000, carry_out=1 (carry recirculates through all 4 nibbles); add_ci observed 0,1,1,1.
3. 0x000A + 0x0002, ci=1 -> sum=0x000D, carry_out=0. Then hold out_ready=0 for 5 cycles -> sum, out_valid and in_ready=0 stable; release -> IDLE next cycle.
4. Assert reset for 1 cycle at count=2 of RUN with out_ready=1 -> out_valid never asserts, in_ready=1 the cycle after reset drops, and a new op (0x1234+0x1111) yields 0x2345.
5. Back-to-back in_valid held high with out_ready=1 -> a new accept every 6 cycles; results match the reference sum each time.
6. SERIAL_ADD_OVF_EN defined: 0x7FFF+0x0001 -> ovf=1, carry_out=0; 0x8000+0xFFFF -> ovf=1, carry_out=1; 0x1000+0x2000 -> ovf=0.
